imm_encoder: RTL and testbench

//  Inverse of the immediate sign-extend/decode path: packs a 32-bit signed immediate into the
//  I/S/B/U/J bit fields of a base RV32I instruction word. Validates opcode, alignment and range.
//  Two-stage valid/ready pipeline used by the program loader / self-test instruction generator,

---
 rtl/imm_encoder.sv | 172 +++++++++++++++++
 tb/tb_imm_encoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// Two-stage valid/ready encoder that packs a signed immediate into the I/S/B/U/J fields of an
// RV32I instruction word. It validates the format, opcode, alignment and range of each request.
module imm_encoder #(
  parameter int unsigned CNT_W        = 16,
  parameter bit          CHECK_OPCODE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [2:0]       out_err,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err
);

  localparam logic [2:0] FmtI = 3'd0;
  localparam logic [2:0] FmtS = 3'd1;
  localparam logic [2:0] FmtB = 3'd2;
  localparam logic [2:0] FmtU = 3'd3;
  localparam logic [2:0] FmtJ = 3'd4;

  logic             s1_v_q, s2_v_q;
  logic [2:0]       s1_fmt_q;
  logic [31:0]      s1_imm_q, s1_base_q;
  logic [2:0]       s1_err_q, s2_err_q;
  logic [31:0]      s2_instr_q;
  logic [CNT_W-1:0] cnt_ok_q, cnt_err_q;

  logic        adv2, accept, deliver;
  logic [2:0]  chk_err;
  logic        op_ok, misaligned, out_of_range;
  logic [6:0]  opcode;
  logic [31:0] field_mask, field_val, packed_instr;

  assign adv2     = !s2_v_q || out_ready;
  assign in_ready = !s1_v_q || adv2;
  assign accept   = in_valid && in_ready;
  assign deliver  = s2_v_q && out_ready;
  assign opcode   = in_base[6:0];

  // Request checks are evaluated at the input so S1 only carries the resulting code.
  always_comb begin
    op_ok        = 1'b0;
    misaligned   = 1'b0;
    out_of_range = 1'b0;
    case (in_fmt)
      FmtI: begin
        op_ok        = opcode inside {7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011};
        out_of_range = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      end
      FmtS: begin
        op_ok        = (opcode == 7'b0100011);
        out_of_range = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      end
      FmtB: begin
        op_ok        = (opcode == 7'b1100011);
        misaligned   = in_imm[0];
        out_of_range = !((&in_imm[31:12]) || !(|in_imm[31:12]));
      end
      FmtU: begin
        op_ok        = opcode inside {7'b0110111, 7'b0010111};
        misaligned   = |in_imm[11:0];
      end
      FmtJ: begin
        op_ok        = (opcode == 7'b1101111);
        misaligned   = in_imm[0];
        out_of_range = !((&in_imm[31:20]) || !(|in_imm[31:20]));
      end
      default: ;
    endcase
  end

  always_comb begin
    chk_err = 3'd0;
    if (in_fmt > FmtJ)                chk_err = 3'd1;
    else if (CHECK_OPCODE && !op_ok)  chk_err = 3'd2;
    else if (misaligned)              chk_err = 3'd3;
    else if (out_of_range)            chk_err = 3'd4;
  end

  always_comb begin
    field_mask = '0;
    field_val  = '0;
    case (s1_fmt_q)
      FmtI: begin
        field_mask = 32'hFFF0_0000;
        field_val  = {s1_imm_q[11:0], 20'b0};
      end
      FmtS: begin
        field_mask = 32'hFE00_0F80;
        field_val  = {s1_imm_q[11:5], 13'b0, s1_imm_q[4:0], 7'b0};
      end
      FmtB: begin
        field_mask = 32'hFE00_0F80;
        field_val  = {s1_imm_q[12], s1_imm_q[10:5], 13'b0, s1_imm_q[4:1], s1_imm_q[11], 7'b0};
      end
      FmtU: begin
        field_mask = 32'hFFFF_F000;
        field_val  = {s1_imm_q[31:12], 12'b0};
      end
      FmtJ: begin
        field_mask = 32'hFFFF_F000;
        field_val  = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12], 12'b0};
      end
      default: ;
    endcase
    // Errored requests return the base with the immediate field cleared.
    packed_instr = (s1_base_q & ~field_mask) | ((s1_err_q == 3'd0) ? field_val : 32'h0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_v_q    <= 1'b0;
      s1_fmt_q  <= '0;
      s1_imm_q  <= '0;
      s1_base_q <= '0;
      s1_err_q  <= '0;
    end else if (in_ready) begin
      s1_v_q <= in_valid;
      if (accept) begin
        s1_fmt_q  <= in_fmt;
        s1_imm_q  <= in_imm;
        s1_base_q <= in_base;
        s1_err_q  <= chk_err;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_v_q     <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= '0;
    end else if (adv2) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_instr_q <= packed_instr;
        s2_err_q   <= s1_err_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_ok_q  <= '0;
      cnt_err_q <= '0;
    end else if (clr_cnt) begin
      cnt_ok_q  <= '0;
      cnt_err_q <= '0;
    end else if (deliver) begin
      if (s2_err_q == 3'd0) begin
        if (cnt_ok_q != '1) cnt_ok_q <= cnt_ok_q + CNT_W'(1);
      end else begin
        if (cnt_err_q != '1) cnt_err_q <= cnt_err_q + CNT_W'(1);
      end
    end
  end

  assign out_valid = s2_v_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;
  assign cnt_ok    = cnt_ok_q;
  assign cnt_err   = cnt_err_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: a CNT_W=2 checked instance and a CNT_W=16 instance with the
// opcode check disabled, both driven by the same stimulus.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [2:0]  in_fmt;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        out_ready;
  logic        clr_cnt;

  logic        in_ready, out_valid;
  logic [31:0] out_instr;
  logic [2:0]  out_err;
  logic [1:0]  cnt_ok, cnt_err;

  logic        in_ready2, out_valid2;
  logic [31:0] out_instr2;
  logic [2:0]  out_err2;
  logic [15:0] cnt_ok2, cnt_err2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_encoder #(.CNT_W(2), .CHECK_OPCODE(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
    .in_imm(in_imm), .in_base(in_base), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .clr_cnt(clr_cnt), .cnt_ok(cnt_ok),
    .cnt_err(cnt_err)
  );

  imm_encoder #(.CNT_W(16), .CHECK_OPCODE(1'b0)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2), .in_fmt(in_fmt),
    .in_imm(in_imm), .in_base(in_base), .out_valid(out_valid2), .out_ready(out_ready),
    .out_instr(out_instr2), .out_err(out_err2), .clr_cnt(clr_cnt), .cnt_ok(cnt_ok2),
    .cnt_err(cnt_err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] fmt, input logic [31:0] imm, input logic [31:0] base);
    in_valid = 1'b1;
    in_fmt   = fmt;
    in_imm   = imm;
    in_base  = base;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_fmt   = 3'd0;
    in_imm   = 32'h0;
    in_base  = 32'h0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] instr, input logic [2:0] err);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_instr"}, out_instr, instr);
    chk({tag, "_err"}, {29'b0, out_err}, {29'b0, err});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
    idle();
    tick(); tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_cnt_ok", {30'b0, cnt_ok}, 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // T1: I-type, latency 2
    push(3'd0, 32'hFFFF_FFFF, 32'h0000_0093);
    tick(); idle();
    chk("t1_lat1", {31'b0, out_valid}, 32'd0);
    tick();
    expect_out("t1", 32'hFFF0_0093, 3'd0);
    tick();

    // T2: S/B/U back-to-back
    push(3'd1, 32'd8, 32'h0020_A023);
    tick(); push(3'd2, 32'hFFFF_FFFC, 32'h0000_0063);
    tick(); expect_out("t2_s", 32'h0020_A423, 3'd0);
    push(3'd3, 32'h1234_5000, 32'h0000_00B7);
    tick(); expect_out("t2_b", 32'hFE00_0EE3, 3'd0);
    idle();
    tick(); expect_out("t2_u", 32'h1234_50B7, 3'd0);
    tick();
    chk("t2_drain", {31'b0, out_valid}, 32'd0);

    // T3: error codes
    push(3'd4, 32'd3, 32'h0000_006F);
    tick(); push(3'd0, 32'd2048, 32'h0000_0093);
    tick(); expect_out("t3_misal", 32'h0000_006F, 3'd3);
    push(3'd6, 32'h0, 32'hDEAD_BEEF);
    tick(); expect_out("t3_range", 32'h0000_0093, 3'd4);
    push(3'd1, 32'h0, 32'h0000_0013);
    tick(); expect_out("t3_fmt", 32'hDEAD_BEEF, 3'd1);
    idle();
    tick(); expect_out("t3_opc", 32'h0000_0013, 3'd2);
    chk("t3_opc_off_err", {29'b0, out_err2}, 32'd0);
    chk("t3_opc_off_instr", out_instr2, 32'h0000_0013);
    tick();
    chk("t3_cnt_ok_sat", {30'b0, cnt_ok}, 32'd3);
    chk("t3_cnt_err_sat", {30'b0, cnt_err}, 32'd3);
    chk("t3_cnt_ok16", {16'b0, cnt_ok2}, 32'd5);
    chk("t3_cnt_err16", {16'b0, cnt_err2}, 32'd3);

    // T4: backpressure
    out_ready = 1'b0;
    push(3'd0, 32'd1, 32'h0000_0013);
    #1 chk("t4_rdy0", {31'b0, in_ready}, 32'd1);
    tick(); push(3'd0, 32'd2, 32'h0000_0013);
    chk("t4_rdy1", {31'b0, in_ready}, 32'd1);
    tick(); push(3'd0, 32'd3, 32'h0000_0013);
    for (int i = 0; i < 3; i++) begin
      chk("t4_stall_rdy", {31'b0, in_ready}, 32'd0);
      chk("t4_stall_instr", out_instr, 32'h0010_0013);
      tick();
    end
    out_ready = 1'b1;
    #1 expect_out("t4_r0", 32'h0010_0013, 3'd0);
    tick(); push(3'd0, 32'd4, 32'h0000_0013);
    expect_out("t4_r1", 32'h0020_0013, 3'd0);
    tick(); idle();
    expect_out("t4_r2", 32'h0030_0013, 3'd0);
    tick(); expect_out("t4_r3", 32'h0040_0013, 3'd0);
    tick();
    chk("t4_drain", {31'b0, out_valid}, 32'd0);

    // T5: counter saturation and clear-wins
    clr_cnt = 1'b1;
    tick(); clr_cnt = 1'b0;
    chk("t5_clr", {30'b0, cnt_ok}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      push(3'd0, i, 32'h0000_0013);
      tick();
    end
    idle();
    tick(); tick();
    chk("t5_sat", {30'b0, cnt_ok}, 32'd3);
    chk("t5_cnt16", {16'b0, cnt_ok2}, 32'd5);
    push(3'd0, 32'd7, 32'h0000_0013);
    tick(); idle();
    tick();
    clr_cnt = 1'b1;
    chk("t5_hs_valid", {31'b0, out_valid}, 32'd1);
    tick(); clr_cnt = 1'b0;
    chk("t5_clr_hs", {30'b0, cnt_ok}, 32'd0);
    chk("t5_clr_hs16", {16'b0, cnt_ok2}, 32'd0);

    // T6: async reset mid-stream
    push(3'd0, 32'd1, 32'h0000_0013);
    tick(); push(3'd0, 32'd2, 32'h0000_0013);
    tick(); push(3'd0, 32'd3, 32'h0000_0013);
    tick(); idle();
    chk("t6_pre_cnt", {16'b0, cnt_ok2}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_rst_instr", out_instr, 32'h0);
    chk("t6_rst_cnt", {16'b0, cnt_ok2}, 32'd0);
    #2 reset = 1'b1;
    tick();
    push(3'd3, 32'hABCD_E000, 32'h0000_0017);
    tick(); idle();
    chk("t6_lat1", {31'b0, out_valid}, 32'd0);
    tick(); expect_out("t6_post", 32'hABCD_E017, 3'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
